mips_cpu_store_buffer: RTL and testbench
========================================

// Module: mips_cpu_store_buffer
// PURPOSE
//  Downstream of the store filter. Accepts right-justified SB/SH/SW store data plus byte address,
//  forms byte enables and lane-shifted write data, and queues the result in a DEPTH-entry FIFO.
//  The FIFO drains in order to the Avalon-MM data bus, which has a waitrequest handshake.
//  The core stalls on st_ready and checks empty before issuing loads, which keeps memory ordering.
// PARAMETERS
//  DEPTH   2   FIFO entries; power of two, >=2
// PORTS
//  clk              in   1   system clock, rising edge
//  reset_n          in   1   asynchronous, active-low reset
//  st_valid         in   1   store request valid
//  st_ready         out  1   buffer can accept; equals !full
//  st_op            in   6   opcode: 101000 SB, 101001 SH, 101011 SW
//  st_addr          in   32  byte address of the store
//  st_data          in   32  right-justified data from the store filter
//  st_err           out  1   one-cycle pulse: previous accepted request misaligned or bad op
//  empty            out  1   no stores queued or in flight
//  avm_address      out  32  word-aligned address ({addr[31:2],2'b00})
//  avm_write        out  1   write request
//  avm_writedata    out  32  lane-aligned write data
//  avm_byteenable   out  4   byte lane enables
//  avm_waitrequest  in   1   slave stall
// BEHAVIOUR
//  Reset: asynchronous. Count, read pointer and write pointer go to 0; st_err=0; empty=1.
//   avm_write, avm_address, avm_writedata and avm_byteenable go to 0. st_ready=1 after release.
//   All queued stores are discarded. avm_write falls immediately, even mid-transfer.
//  Accept: accepted = st_valid && st_ready. st_ready = (count != DEPTH).
//   st_ready does not look at same-cycle pop, so nothing is pushed while full.
//  Lane mapping is little-endian. With k = st_addr[1:0]:
//   SB: be = 4'b0001 << k; data = st_data[7:0] << 8k
//   SH: k[0] must be 0; be = 4'b0011 << k; data = st_data[15:0] << 8k
//   SW: k must be 0; be = 4'b1111; data = st_data
//   Unused lanes of writedata are 0.
//  Errors: a misaligned SH/SW or any other opcode is still consumed by the handshake but is not queued.
//   st_err is registered and is 1 for exactly the cycle after acceptance.
//  FIFO: each entry holds {word address, data, be}. Push on an accepted, valid request.
//   pop = avm_write && !avm_waitrequest. Pointers wrap modulo DEPTH.
//   Count width is $clog2(DEPTH)+1.
//   Push and pop in the same cycle leave count unchanged; both pointers advance.
//  Bus outputs are registered from the FIFO head.
//   avm_write=1 from the cycle after an entry becomes head, while count!=0.
//   Latency: request accepted in cycle N into an empty buffer gives avm_write=1 in cycle N+1.
//   While avm_write=1 and avm_waitrequest=1, address, writedata and byteenable are held stable.
//   After a pop, the next entry is presented in the following cycle, or avm_write drops to 0.
//   Back-to-back writes are allowed; there is no idle cycle between entries.
//  empty = (count == 0) && !avm_write.
//  Two FSM states:
//   IDLE: avm_write=0. Goes to BUSY when count != 0.
//   BUSY: avm_write=1. On pop, stays in BUSY if entries remain, otherwise returns to IDLE.
// TESTING
//  1. SB addr 0x00001003, data 0x000000AB, waitrequest=0 -> next cycle: address 0x00001000,
//     be 1000, writedata 0xAB000000, avm_write high 1 cycle, then empty=1.
//  2. SH addr 0x00002002, data 0x00001234 -> be 1100, writedata 0x12340000, address 0x00002000.
//  3. SW addr 0x00003001, and separately op 6'b100011 -> st_err pulses 1 cycle each, avm_write
//     stays 0, st_ready stays 1, empty stays 1.
//  4. DEPTH=2, waitrequest held 1 for 6 cycles, push SW A, B, C -> st_ready=0 once full.
//     Bus signals stay stable on A; after release, A, B, C are written in order;
//     C is accepted only after A pops.
//  5. Count=1 with waitrequest=0, push in the same cycle -> count stays 1; no idle cycle on the bus
//     between the two writes.
//  6. reset_n driven low while avm_write=1 with 2 entries queued -> avm_write=0 and empty=1 in the
//     same cycle; after release no stale write appears.

Source files
------------

// File: rtl/mips_cpu_store_buffer.sv
// Store buffer: turns right-justified SB/SH/SW requests into Avalon-MM byte-lane writes
// and queues them in a DEPTH-entry in-order FIFO drained under waitrequest.
module mips_cpu_store_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [5:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_err,
    output logic        empty,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  count_reg, count_next;
    logic [AW-1:0]  rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
    logic           st_err_reg;
    logic [29:0]    avm_address_reg;
    logic [31:0]    avm_writedata_reg;
    logic [3:0]     avm_byteenable_reg;

    logic [29:0]    mem_addr [DEPTH];
    logic [31:0]    mem_data [DEPTH];
    logic [3:0]     mem_be   [DEPTH];

    logic           accepted, req_ok, push, pop, load, head_from_req;
    logic [3:0]     req_be;
    logic [31:0]    req_shifted, req_data;

    // Decode opcode and alignment into byte enables
    always_comb begin
        req_ok = 1'b0;
        req_be = 4'b0000;
        case (st_op)
            OP_SB: begin
                req_ok = 1'b1;
                req_be = 4'b0001 << st_addr[1:0];
            end
            OP_SH: begin
                req_ok = ~st_addr[0];
                req_be = 4'b0011 << st_addr[1:0];
            end
            OP_SW: begin
                req_ok = (st_addr[1:0] == 2'b00);
                req_be = 4'b1111;
            end
            default: begin
                req_ok = 1'b0;
                req_be = 4'b0000;
            end
        endcase
    end

    assign req_shifted = st_data << {st_addr[1:0], 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign req_data[8*gi +: 8] = req_be[gi] ? req_shifted[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign st_ready = (count_reg != CW'(DEPTH));
    assign accepted = st_valid && st_ready;
    assign push     = accepted && req_ok;
    assign pop      = (state_reg == BUSY) && !avm_waitrequest;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // The next head is being written this very cycle when nothing else survives the pop
    assign rd_ptr_next   = rd_ptr_reg + AW'(pop);
    assign head_from_req = (count_reg == CW'(pop));

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_next != '0) begin
                    state_next = BUSY;
                    load       = 1'b1;
                end
            end
            BUSY: begin
                if (pop) begin
                    if (count_next != '0) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_reg] <= st_addr[31:2];
            mem_data[wr_ptr_reg] <= req_data;
            mem_be[wr_ptr_reg]   <= req_be;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= IDLE;
            count_reg          <= '0;
            rd_ptr_reg         <= '0;
            wr_ptr_reg         <= '0;
            st_err_reg         <= 1'b0;
            avm_address_reg    <= '0;
            avm_writedata_reg  <= '0;
            avm_byteenable_reg <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            st_err_reg <= accepted && !req_ok;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (load) begin
                if (head_from_req) begin
                    avm_address_reg    <= st_addr[31:2];
                    avm_writedata_reg  <= req_data;
                    avm_byteenable_reg <= req_be;
                end else begin
                    avm_address_reg    <= mem_addr[rd_ptr_next];
                    avm_writedata_reg  <= mem_data[rd_ptr_next];
                    avm_byteenable_reg <= mem_be[rd_ptr_next];
                end
            end
        end
    end

    assign avm_write      = (state_reg == BUSY);
    assign avm_address    = {avm_address_reg, 2'b00};
    assign avm_writedata  = avm_writedata_reg;
    assign avm_byteenable = avm_byteenable_reg;
    assign st_err         = st_err_reg;
    assign empty          = (count_reg == '0) && !avm_write;

endmodule

// File: tb/tb_mips_cpu_store_buffer.sv
// Bench for mips_cpu_store_buffer: directed lane-mapping table, hand-written
// backpressure/reset sequences, then random traffic against a queue model.
module tb_mips_cpu_store_buffer;
    localparam int DEPTH = 2;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_LW = 6'b100011;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [5:0]  st_op = '0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_err;
    logic        empty;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;

    int errors = 0;
    int checks = 0;

    mips_cpu_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data), .st_err(st_err), .empty(empty),
        .avm_address(avm_address), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    vec_t vecs[10];
    wr_t  model_q[$];
    logic model_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        st_valid = 1'b0;
        avm_waitrequest = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        model_q.delete();
        model_err = 1'b0;
    endtask

    // Reference lane mapping: byte i of the store lands in lane (addr%4)+i
    function automatic void ref_store(input logic [5:0] op, input logic [31:0] addr,
                                      input logic [31:0] data, output logic ok,
                                      output wr_t w);
        int size;
        int lane;
        size = (op == OP_SB) ? 1 : (op == OP_SH) ? 2 : (op == OP_SW) ? 4 : 0;
        ok = 1'b0;
        if (size != 0) ok = ((addr % size) == 0);
        w.addr = {addr[31:2], 2'b00};
        w.data = '0;
        w.be   = '0;
        if (ok) begin
            for (int i = 0; i < size; i++) begin
                lane = int'(addr % 4) + i;
                w.be[lane] = 1'b1;
                w.data[lane*8 +: 8] = data[i*8 +: 8];
            end
        end
    endfunction

    // Compare outputs with the model, then advance DUT and model by one clock
    task automatic model_cycle();
        logic ok;
        logic acc;
        logic pop;
        wr_t  w;
        chk("rnd_avm_write", 32'(avm_write), 32'(model_q.size() != 0));
        chk("rnd_empty", 32'(empty), 32'(model_q.size() == 0));
        chk("rnd_st_ready", 32'(st_ready), 32'(model_q.size() != DEPTH));
        chk("rnd_st_err", 32'(st_err), 32'(model_err));
        if (model_q.size() != 0) begin
            chk("rnd_address", avm_address, model_q[0].addr);
            chk("rnd_writedata", avm_writedata, model_q[0].data);
            chk("rnd_byteenable", 32'(avm_byteenable), 32'(model_q[0].be));
        end
        acc = st_valid && (model_q.size() != DEPTH);
        pop = (model_q.size() != 0) && !avm_waitrequest;
        ref_store(st_op, st_addr, st_data, ok, w);
        if (pop) begin
            $display("write addr=0x%08h data=0x%08h be=%b", model_q[0].addr,
                     model_q[0].data, model_q[0].be);
            void'(model_q.pop_front());
        end
        if (acc && ok) model_q.push_back(w);
        model_err = acc && !ok;
        tick();
    endtask

    initial begin
        vecs[0] = '{OP_SB, 32'h0000_1003, 32'h0000_00AB, 1'b0, 32'h0000_1000, 4'b1000, 32'hAB00_0000};
        vecs[1] = '{OP_SB, 32'h0000_1001, 32'hFFFF_FF5A, 1'b0, 32'h0000_1000, 4'b0010, 32'h0000_5A00};
        vecs[2] = '{OP_SB, 32'h0000_1000, 32'h0000_0011, 1'b0, 32'h0000_1000, 4'b0001, 32'h0000_0011};
        vecs[3] = '{OP_SH, 32'h0000_2002, 32'h0000_1234, 1'b0, 32'h0000_2000, 4'b1100, 32'h1234_0000};
        vecs[4] = '{OP_SH, 32'h0000_2000, 32'hABCD_1234, 1'b0, 32'h0000_2000, 4'b0011, 32'h0000_1234};
        vecs[5] = '{OP_SW, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF};
        vecs[6] = '{OP_SW, 32'h0000_3001, 32'h1111_1111, 1'b1, 32'h0, 4'b0000, 32'h0};
        vecs[7] = '{OP_SH, 32'h0000_2001, 32'h2222_2222, 1'b1, 32'h0, 4'b0000, 32'h0};
        vecs[8] = '{OP_LW, 32'h0000_0000, 32'h3333_3333, 1'b1, 32'h0, 4'b0000, 32'h0};
        vecs[9] = '{OP_SW, 32'hFFFF_FFFC, 32'h0123_4567, 1'b0, 32'hFFFF_FFFC, 4'b1111, 32'h0123_4567};

        // Reset state, observed while reset is held
        reset_n = 1'b0;
        #12;
        chk("reset_avm_write", 32'(avm_write), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_st_err", 32'(st_err), 32'd0);
        chk("reset_address", avm_address, 32'd0);
        chk("reset_writedata", avm_writedata, 32'd0);
        chk("reset_byteenable", 32'(avm_byteenable), 32'd0);
        do_reset();
        chk("reset_st_ready", 32'(st_ready), 32'd1);

        // Lane-mapping table: one request, single-cycle write next cycle, then idle
        for (int i = 0; i < 10; i++) begin
            st_valid = 1'b1;
            st_op    = vecs[i].op;
            st_addr  = vecs[i].addr;
            st_data  = vecs[i].data;
            tick();
            st_valid = 1'b0;
            chk("vec_st_err", 32'(st_err), 32'(vecs[i].err));
            chk("vec_avm_write", 32'(avm_write), 32'(!vecs[i].err));
            chk("vec_st_ready", 32'(st_ready), 32'd1);
            if (!vecs[i].err) begin
                chk("vec_address", avm_address, vecs[i].exp_addr);
                chk("vec_byteenable", 32'(avm_byteenable), 32'(vecs[i].exp_be));
                chk("vec_writedata", avm_writedata, vecs[i].exp_wdata);
                $display("vec %0d write addr=0x%08h data=0x%08h be=%b", i, avm_address,
                         avm_writedata, avm_byteenable);
            end else begin
                chk("vec_empty_err", 32'(empty), 32'd1);
                $display("vec %0d rejected op=%b addr=0x%08h", i, vecs[i].op, vecs[i].addr);
            end
            tick();
            chk("vec_drop_write", 32'(avm_write), 32'd0);
            chk("vec_drop_err", 32'(st_err), 32'd0);
            chk("vec_empty", 32'(empty), 32'd1);
        end

        // Backpressure: A, B fill the buffer, C waits until A pops
        do_reset();
        avm_waitrequest = 1'b1;
        st_valid = 1'b1; st_op = OP_SW; st_addr = 32'h0000_0A00; st_data = 32'hAAAA_0001;
        tick();
        chk("bp_a_write", 32'(avm_write), 32'd1);
        chk("bp_a_address", avm_address, 32'h0000_0A00);
        st_addr = 32'h0000_0B00; st_data = 32'hBBBB_0002;
        tick();
        st_addr = 32'h0000_0C00; st_data = 32'hCCCC_0003;
        for (int i = 0; i < 4; i++) begin
            chk("bp_full_ready", 32'(st_ready), 32'd0);
            chk("bp_hold_address", avm_address, 32'h0000_0A00);
            chk("bp_hold_data", avm_writedata, 32'hAAAA_0001);
            chk("bp_hold_write", 32'(avm_write), 32'd1);
            tick();
        end
        avm_waitrequest = 1'b0;
        tick();
        $display("bp write A popped");
        chk("bp_b_address", avm_address, 32'h0000_0B00);
        chk("bp_b_data", avm_writedata, 32'hBBBB_0002);
        chk("bp_ready_after_pop", 32'(st_ready), 32'd1);
        tick();
        st_valid = 1'b0;
        $display("bp write B popped, C pushed");
        chk("bp_c_write", 32'(avm_write), 32'd1);
        chk("bp_c_address", avm_address, 32'h0000_0C00);
        chk("bp_c_data", avm_writedata, 32'hCCCC_0003);
        chk("bp_count_one_ready", 32'(st_ready), 32'd1);
        tick();
        $display("bp write C popped");
        chk("bp_done_write", 32'(avm_write), 32'd0);
        chk("bp_done_empty", 32'(empty), 32'd1);

        // Asynchronous reset in the middle of a stalled transfer
        avm_waitrequest = 1'b1;
        st_valid = 1'b1; st_op = OP_SW; st_addr = 32'h0000_0D00; st_data = 32'h1;
        tick();
        st_addr = 32'h0000_0E00;
        tick();
        st_valid = 1'b0;
        chk("rst_pre_write", 32'(avm_write), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_write", 32'(avm_write), 32'd0);
        chk("rst_async_empty", 32'(empty), 32'd1);
        tick();
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_stale_write", 32'(avm_write), 32'd0);
        end
        $display("reset mid-transfer discarded queued stores");

        // Random traffic against the queue model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            st_valid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 4))
                0: st_op = OP_SB;
                1: st_op = OP_SH;
                2: st_op = OP_SW;
                3: st_op = OP_SW;
                default: st_op = 6'($urandom);
            endcase
            st_addr = $urandom;
            st_data = $urandom;
            avm_waitrequest = ($urandom_range(0, 9) < 4);
            model_cycle();
        end
        st_valid = 1'b0;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) model_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
